arm_mc_controller: RTL and testbench

Multi-cycle control unit for the ARM datapath. It decodes the upper instruction fields, steps a per-instruction state machine, and drives `ALUControl`/`RegControl` into the ALU. It also consumes the ALU's `ALUFlags`, holding them in an architectural NZCV register that gates conditional execution. It replaces the single-cycle decoder when the datapath shares one memory and one ALU across cycles.

---
 rtl/arm_ctrl_pkg.sv | 73 +++++++
 rtl/arm_cond_check.sv | 38 +++
 rtl/arm_mc_controller.sv | 182 ++++++++++++++++++
 tb/tb_arm_mc_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multi-cycle ARM control unit.
// Contents: FSM state enum, ALUControl / RegControl encodings,
// ARM data-processing cmd codes, condition codes and Op field codes.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // ALUControl encodings
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_ORR = 4'b0011;
    localparam logic [3:0] ALU_RSB = 4'b0101;
    localparam logic [3:0] ALU_MOV = 4'b0110;
    localparam logic [3:0] ALU_EOR = 4'b0111;
    localparam logic [3:0] ALU_BIC = 4'b1010;
    localparam logic [3:0] ALU_MVN = 4'b1110;

    // RegControl (shifter) encodings
    localparam logic [1:0] RC_PASS = 2'b00;
    localparam logic [1:0] RC_LSL  = 2'b01;
    localparam logic [1:0] RC_LSR  = 2'b10;
    localparam logic [1:0] RC_ASR  = 2'b11;

    // ARM data-processing cmd field
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_RSB = 4'b0011;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_TEQ = 4'b1001;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;
    localparam logic [3:0] CMD_MVN = 4'b1111;

    // ARM condition field
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Op field
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluator.
// Ports: cond_i  - instruction condition field
//        flags_i - {N,Z,C,V}
//        cond_ex_o - 1 when the instruction should execute (1111 -> 0)
module arm_cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;

    always_comb begin
        {n, z, c, v} = flags_i;
        cond_ex_o    = 1'b0;
        unique case (cond_i)
            COND_EQ: cond_ex_o = z;
            COND_NE: cond_ex_o = ~z;
            COND_CS: cond_ex_o = c;
            COND_CC: cond_ex_o = ~c;
            COND_MI: cond_ex_o = n;
            COND_PL: cond_ex_o = ~n;
            COND_VS: cond_ex_o = v;
            COND_VC: cond_ex_o = ~v;
            COND_HI: cond_ex_o = c & ~z;
            COND_LS: cond_ex_o = ~c | z;
            COND_GE: cond_ex_o = (n == v);
            COND_LT: cond_ex_o = (n != v);
            COND_GT: cond_ex_o = ~z & (n == v);
            COND_LE: cond_ex_o = z | (n != v);
            COND_AL: cond_ex_o = 1'b1;
            default: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multi-cycle ARM control unit: decodes the upper instruction fields,
// sequences FETCH/DECODE/execute/writeback states and holds the NZCV flags.
// Inputs : clk, reset_n (sync, active low), Cond, Op, Funct, Rd, Sh, ALUFlags
// Outputs: write enables (PCWrite, MemWrite, RegWrite, IRWrite), datapath
//          muxes (AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc),
//          ALU selects (ALUControl, RegControl) and the Flags register.
module arm_mc_controller
    import arm_ctrl_pkg::*;
#(
    parameter logic [1:0] BRANCH_OFFSET_SRC = 2'b10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [1:0] Sh,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic [1:0] RegControl,
    output logic [3:0] Flags
);

    state_t     state_q, state_d, state_out;
    logic       condex_q;
    logic [3:0] flags_q;
    logic       cond_ex;

    logic [3:0] cmd;
    logic [3:0] alu_dec;
    logic       nowrite, arith, dp_valid, flag_we;
    logic       pcw, mw, rw, irw;

    assign cmd = Funct[4:1];

    arm_cond_check u_cond (
        .cond_i    (Cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_ex)
    );

    // cmd -> ALU operation, write suppression and C/V update class
    always_comb begin
        alu_dec  = ALU_ADD;
        nowrite  = 1'b0;
        arith    = 1'b0;
        dp_valid = 1'b1;
        unique case (cmd)
            CMD_AND: alu_dec = ALU_AND;
            CMD_EOR: alu_dec = ALU_EOR;
            CMD_SUB: begin alu_dec = ALU_SUB; arith = 1'b1; end
            CMD_RSB: begin alu_dec = ALU_RSB; arith = 1'b1; end
            CMD_ADD: begin alu_dec = ALU_ADD; arith = 1'b1; end
            CMD_TST: begin alu_dec = ALU_AND; nowrite = 1'b1; end
            CMD_TEQ: begin alu_dec = ALU_EOR; nowrite = 1'b1; end
            CMD_CMP: begin alu_dec = ALU_SUB; nowrite = 1'b1; arith = 1'b1; end
            CMD_CMN: begin alu_dec = ALU_ADD; nowrite = 1'b1; arith = 1'b1; end
            CMD_ORR: alu_dec = ALU_ORR;
            CMD_MOV: alu_dec = ALU_MOV;
            CMD_BIC: alu_dec = ALU_BIC;
            CMD_MVN: alu_dec = ALU_MVN;
            default: begin alu_dec = ALU_ADD; nowrite = 1'b1; dp_valid = 1'b0; end
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (Op == OP_MEM)     state_d = S_MEMADR;
                else if (Op == OP_DP) state_d = Funct[5] ? S_EXECI : S_EXECR;
                else if (Op == OP_BR) state_d = S_BRANCH;
                else                  state_d = S_FETCH;
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    assign flag_we = ((state_q == S_EXECR) || (state_q == S_EXECI))
                     && Funct[0] && condex_q && dp_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_FETCH;
            condex_q <= 1'b0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                condex_q <= cond_ex;
            if (flag_we) begin
                flags_q[3:2] <= ALUFlags[3:2];
                if (arith)
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // While in reset the datapath sees FETCH settings with all writes blocked.
    always_comb begin
        state_out  = reset_n ? state_q : S_FETCH;
        pcw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        irw        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        RegControl = RC_PASS;
        if (state_out != S_FETCH)
            RegSrc = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};
        unique case (state_out)
            S_FETCH: begin
                irw = 1'b1; pcw = 1'b1;
                ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01; ALUSrcB = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01; ImmSrc = 2'b01;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01; rw = condex_q;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1; mw = condex_q;
            end
            S_EXECR: begin
                ALUControl = alu_dec;
                if (cmd == CMD_MOV) begin
                    unique case (Sh)
                        2'b00:   RegControl = RC_LSL;
                        2'b01:   RegControl = RC_LSR;
                        2'b10:   RegControl = RC_ASR;
                        default: RegControl = RC_PASS;
                    endcase
                end
            end
            S_EXECI: begin
                ALUSrcB = 2'b01; ALUControl = alu_dec;
            end
            S_ALUWB: begin
                rw  = condex_q & ~nowrite;
                pcw = condex_q & (Rd == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10;
                ImmSrc = BRANCH_OFFSET_SRC; pcw = condex_q;
            end
            default: ;
        endcase
    end

    assign PCWrite  = reset_n & pcw;
    assign MemWrite = reset_n & mw;
    assign RegWrite = reset_n & rw;
    assign IRWrite  = reset_n & irw;
    assign Flags    = flags_q;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: drives instruction fields, records
// the packed control outputs of every cycle of an instruction and compares
// selected cycles, cycle counts and the Flags register with hand values.
module tb_arm_mc_controller;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op, Sh;
    logic [5:0] Funct;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, RegControl;
    logic [3:0] ALUControl, Flags;

    arm_mc_controller #(.BRANCH_OFFSET_SRC(2'b10)) dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .Sh(Sh), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .RegControl(RegControl),
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    // {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,
    //  ImmSrc,RegSrc,ALUControl,RegControl}
    logic [20:0] outv;
    assign outv = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
                   ResultSrc, ImmSrc, RegSrc, ALUControl, RegControl};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [20:0] rec [0:9];
    int          ncyc;
    logic [20:0] v_fetch;

    function automatic logic [20:0] ov(input logic pcw, input logic mw,
        input logic rw, input logic irw, input logic adr,
        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] rs,
        input logic [1:0] im, input logic [1:0] rsrc,
        input logic [3:0] ac, input logic [1:0] rc);
        return {pcw, mw, rw, irw, adr, sa, sb, rs, im, rsrc, ac, rc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts in a FETCH cycle; returns #1 after the edge that re-enters FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r,
                             input logic [1:0] s, input logic [3:0] af);
        Cond = c; Op = o; Funct = f; Rd = r; Sh = s; ALUFlags = af;
        ncyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rec[i] = outv;
            ncyc++;
            @(posedge clk); #1;
            if (IRWrite) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        v_fetch = ov(1,0,0,1,0,2'b01,2'b10,2'b10,2'b00,2'b00,4'b0000,2'b00);
        reset_n = 1'b0;
        Cond = 4'h0; Op = 2'b10; Funct = '0; Rd = '0; Sh = '0; ALUFlags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outputs", 32'(outv),
                 32'(ov(0,0,0,0,0,2'b01,2'b10,2'b10,2'b00,2'b00,4'b0000,2'b00)));
        check_eq("reset_flags", 32'(Flags), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // ADD R1,R2,R3 (AL, S=0); ALUFlags noise must not reach Flags
        run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 2'b00, 4'b1111);
        check_eq("add_cycles", 32'(ncyc), 32'd4);
        check_eq("add_fetch", 32'(rec[0]), 32'(v_fetch));
        check_eq("add_decode", 32'(rec[1]),
                 32'(ov(0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,2'b00,4'b0000,2'b00)));
        check_eq("add_execr", 32'(rec[2]), 32'h0);
        check_eq("add_aluwb", 32'(rec[3]),
                 32'(ov(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'b0000,2'b00)));
        check_eq("add_flags", 32'(Flags), 32'h0);

        // SUBS then ANDS: C,V kept across the logic op
        run_instr(4'hE, 2'b00, 6'b000101, 4'd1, 2'b00, 4'b0110);
        check_eq("subs_aluctl", 32'(rec[2][5:2]), 32'b0001);
        check_eq("subs_flags", 32'(Flags), 32'b0110);
        run_instr(4'hE, 2'b00, 6'b000001, 4'd1, 2'b00, 4'b1000);
        check_eq("ands_aluctl", 32'(rec[2][5:2]), 32'b0010);
        check_eq("ands_flags", 32'(Flags), 32'b1010);

        // CMP giving Z=1: no register write
        run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 2'b00, 4'b0100);
        check_eq("cmp_cycles", 32'(ncyc), 32'd4);
        check_eq("cmp_regwrite", 32'(rec[3][18]), 32'd0);
        check_eq("cmp_flags", 32'(Flags), 32'b0100);

        // ADDNE with Z=1 is squashed
        run_instr(4'h1, 2'b00, 6'b001000, 4'd2, 2'b00, 4'b0000);
        check_eq("addne_cycles", 32'(ncyc), 32'd4);
        check_eq("addne_aluwb", 32'(rec[3]), 32'h0);

        // ADDSNE with Z=1: flags must not change
        run_instr(4'h1, 2'b00, 6'b001001, 4'd2, 2'b00, 4'b1111);
        check_eq("addsne_flags", 32'(Flags), 32'b0100);

        // BEQ taken
        run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 2'b00, 4'b0000);
        check_eq("beq_cycles", 32'(ncyc), 32'd3);
        check_eq("beq_decode_regsrc", 32'(rec[1][7:6]), 32'b01);
        check_eq("beq_branch", 32'(rec[2]),
                 32'(ov(1,0,0,0,0,2'b10,2'b01,2'b10,2'b10,2'b01,4'b0000,2'b00)));

        // LDR R4,[...]
        run_instr(4'hE, 2'b01, 6'b011001, 4'd4, 2'b00, 4'b0000);
        check_eq("ldr_cycles", 32'(ncyc), 32'd5);
        check_eq("ldr_memadr", 32'(rec[2]),
                 32'(ov(0,0,0,0,0,2'b00,2'b01,2'b00,2'b01,2'b00,4'b0000,2'b00)));
        check_eq("ldr_memrd", 32'(rec[3]),
                 32'(ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,4'b0000,2'b00)));
        check_eq("ldr_memwb", 32'(rec[4]),
                 32'(ov(0,0,1,0,0,2'b00,2'b00,2'b01,2'b00,2'b00,4'b0000,2'b00)));

        // STR R4,[...]
        run_instr(4'hE, 2'b01, 6'b011000, 4'd4, 2'b00, 4'b0000);
        check_eq("str_cycles", 32'(ncyc), 32'd4);
        check_eq("str_memwr", 32'(rec[3]),
                 32'(ov(0,1,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b10,4'b0000,2'b00)));

        // MOV R1,R2,ASR (register form)
        run_instr(4'hE, 2'b00, 6'b011010, 4'd1, 2'b10, 4'b0000);
        check_eq("movasr_execr", 32'(rec[2]),
                 32'(ov(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'b0110,2'b11)));

        // MOV R1,#imm: immediate form uses no shifter code
        run_instr(4'hE, 2'b00, 6'b111010, 4'd1, 2'b10, 4'b0000);
        check_eq("movi_execi", 32'(rec[2]),
                 32'(ov(0,0,0,0,0,2'b00,2'b01,2'b00,2'b00,2'b00,4'b0110,2'b00)));

        // MOV PC,R0
        run_instr(4'hE, 2'b00, 6'b011010, 4'd15, 2'b00, 4'b0000);
        check_eq("movpc_execr_regctl", 32'(rec[2][1:0]), 32'b01);
        check_eq("movpc_aluwb", 32'(rec[3]),
                 32'(ov(1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,4'b0000,2'b00)));

        // Op=11 no-op and cond=1111 (never)
        run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 2'b00, 4'b0000);
        check_eq("op11_cycles", 32'(ncyc), 32'd2);
        run_instr(4'hF, 2'b00, 6'b001000, 4'd3, 2'b00, 4'b0000);
        check_eq("nv_aluwb_regwrite", 32'(rec[3][18]), 32'd0);

        // Reset pulsed during STR's MEMWR
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check_eq("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        check_eq("pre_reset_flags", 32'(Flags), 32'b0100);
        #1 reset_n = 1'b0;
        #1;
        check_eq("reset_memwrite", 32'(MemWrite), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("after_reset_fetch", 32'(outv), 32'(v_fetch));
        check_eq("after_reset_flags", 32'(Flags), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
